i2s_line_in_receiver: RTL and testbench
=======================================

# i2s_line_in_receiver

Receives the ADAU1761's serial capture stream: it deserializes the I2S line-in data, which the codec drives, into parallel left/right samples in the `clk` domain. It is the receive-direction counterpart of the codec's headphone transmit path. It samples the codec-driven bit clock, channel clock and data pins, locks to the frame, and presents one stereo sample pair per frame with a single-cycle strobe. Downstream consumers (wave display, effects) use `line_in_l`/`line_in_r` qualified by `new_sample`.

## Interface
- `SAMPLE_WIDTH`, 24: bits captured per channel slot, MSB first.
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: synchronous, active-low; `reset`=0 at a `clk` edge resets the block.
- `i2s_bclk` input 1: codec bit clock, asynchronous to `clk`.
- `i2s_lrclk` input 1: codec channel clock, asynchronous; 0 = left slot, 1 = right slot.
- `i2s_sdata` input 1: codec serial data, asynchronous; changes on `i2s_bclk` falling edge.
- `line_in_l` output SAMPLE_WIDTH: last complete left sample, two's complement.
- `line_in_r` output SAMPLE_WIDTH: last complete right sample, two's complement.
- `new_sample` output 1: one-cycle pulse when `line_in_l`/`line_in_r` update.
- `frame_error` output 1: one-cycle pulse when a slot ended before SAMPLE_WIDTH bits were received.
- `locked` output 1: high while the receiver is frame-aligned (state SHIFT or HOLD).

## Operation
- **Input synchronization:** `i2s_bclk`, `i2s_lrclk` and `i2s_sdata` each pass through an identical 2-flop synchronizer, so the three signals stay mutually aligned. A third `bclk` flop provides edge detection.
- **Bit rise:** a bit rise is the synchronized `bclk` going 0→1. All state changes happen only on bit rises.
- **`lr_prev`:** holds the synchronized `lrclk` from the previous bit rise. A boundary rise is a rise where `lrclk` ≠ `lr_prev`.
- **Delay bit:** per I2S, the data bit sampled on a boundary rise is the delay bit and is discarded. The MSB arrives on the next rise.
- **States:**
  - SYNC: entered on reset. The first bit rise only loads `lr_prev`. On a later boundary rise with `lrclk`=0 (start of a left slot): go to SHIFT, clear `cnt`, set `chan`=L. All other rises stay in SYNC.
  - SHIFT: on each non-boundary rise, shift `sdata` into `shreg` LSB-first-in (MSB lands highest) and increment `cnt`.
    - When `cnt` reaches SAMPLE_WIDTH, commit and go to HOLD.
    - On a boundary rise while `cnt`<SAMPLE_WIDTH: left-align the partial word with zero fill, commit it, pulse `frame_error`, then restart SHIFT for the new channel with `cnt`=0.
  - HOLD: ignore data bits beyond SAMPLE_WIDTH. On a boundary rise: go to SHIFT, clear `cnt`, set `chan`=`lrclk`.
- **Commit, left channel:** `shreg` is written to an internal `left_hold` register, and a left-valid flag is set.
- **Commit, right channel with left-valid set:** `line_in_l`←`left_hold` and `line_in_r`←`shreg`, updated atomically. `new_sample` pulses and left-valid clears.
- **Commit, right channel with left-valid clear:** the sample is dropped and no pulse is generated.
- **Reset:** all registers clear. Outputs go to 0, state goes to SYNC, and any partial word is discarded, including when reset lands mid-slot.
- **Reset priority:** reset has priority over any simultaneous bit rise.

## Timing
- **Reset values:** `line_in_l`=0, `line_in_r`=0, `new_sample`=0, `frame_error`=0, `locked`=0. All synchronizer flops reset to 0.
- **Pipeline timing:** let edge k be the `clk` edge at which sync stage 1 first captures `bclk`=1.
  - Sync stage 2 captures it at k+1.
  - The shift, count and state update is registered at k+2.
  - `line_in_l`/`line_in_r`/`new_sample`/`frame_error` are registered at k+3.
- **Latency:** `new_sample` is high for exactly the one cycle following edge k+3 of the final right bit. Output data is valid in that same cycle and is held until the next commit.
- **`locked`:** rises on the cycle after entry to SHIFT from SYNC; falls on reset.
- **Clock requirement:** `i2s_bclk` high and low phases must each be ≥3 `clk` periods (the codec's 3.072 MHz satisfies this). No glitch filtering is required beyond this.
- **Short slots:** a `frame_error` pulse and a `new_sample` pulse may occur in the same cycle when a short right slot completes a frame.

## Test plan
- **Nominal frame:** 32-bit slots, L=0x123456, R=0xABCDEF, bclk period 32 clk, after lock. Required: exactly one `new_sample` pulse 3 clk after the last R bit's bclk rise reaches sync stage 1; `line_in_l`=0x123456, `line_in_r`=0xABCDEF; `frame_error` stays 0.
- **Startup mid-frame:** release reset mid-right slot. Required: `locked`=0 and no pulse until the next left boundary; the first pulse follows the first complete L+R frame.
- **Short slots:** 16-bit slots, L=0xBEEF, R=0x1234. Required: `line_in_l`=0xBEEF00, `line_in_r`=0x123400; one `frame_error` pulse per slot; one `new_sample` per frame.
- **Overlong slots:** 32-bit slots carrying 0xFF in the 8 trailing bits. Required: outputs unchanged from the nominal-frame values; trailing bits ignored.
- **Reset mid-frame:** assert `reset`=0 for 1 clk during left-slot bit 10. Required: the following cycle shows all outputs 0 and `locked`=0; the next pulse occurs only after a full frame following a fresh left boundary.
- **Full scale, back-to-back:** L=0x800000, R=0x7FFFFF for 4 consecutive frames. Required: 4 pulses spaced exactly 64 bclk apart, with values bit-exact.

Source files
------------

// File: rtl/i2s_line_in_if.sv
// Signal bundle between the I2S capture pins, the line-in receiver and its
// downstream consumers. The receiver takes the master view.
interface i2s_line_in_if #(
  parameter int unsigned SAMPLE_WIDTH = 24
);
  logic                    i2s_bclk;
  logic                    i2s_lrclk;
  logic                    i2s_sdata;
  logic [SAMPLE_WIDTH-1:0] line_in_l;
  logic [SAMPLE_WIDTH-1:0] line_in_r;
  logic                    new_sample;
  logic                    frame_error;
  logic                    locked;

  modport master (
    input  i2s_bclk, i2s_lrclk, i2s_sdata,
    output line_in_l, line_in_r, new_sample, frame_error, locked
  );

  modport slave (
    output i2s_bclk, i2s_lrclk, i2s_sdata,
    input  line_in_l, line_in_r, new_sample, frame_error, locked
  );
endinterface

// File: rtl/i2s_line_in_receiver.sv
// Deserializes the codec's I2S capture stream into parallel stereo samples
// in the clk domain, one pair per frame qualified by a single-cycle strobe.
module i2s_line_in_receiver #(
  parameter int unsigned SAMPLE_WIDTH = 24
) (
  input  logic           clk,
  input  logic           reset,
  i2s_line_in_if.master  bus
);
  localparam int unsigned CW = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {SYNC, SHIFT, HOLD} state_t;

  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lr_s1_q, lr_s2_q;
  logic sd_s1_q, sd_s2_q;

  state_t                  state_q, state_d;
  logic                    lr_prev_q, lr_prev_d;
  logic                    primed_q, primed_d;
  logic                    chan_q, chan_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;

  logic                    cmt_q, cmt_d;
  logic                    cmt_chan_q, cmt_chan_d;
  logic                    cmt_err_q, cmt_err_d;
  logic [SAMPLE_WIDTH-1:0] cmt_word_q, cmt_word_d;

  logic [SAMPLE_WIDTH-1:0] left_hold_q;
  logic                    left_valid_q;
  logic [SAMPLE_WIDTH-1:0] line_l_q, line_r_q;
  logic                    new_sample_q, frame_error_q;

  logic          rise, boundary;
  logic [CW-1:0] pad;

  assign rise     = bclk_s2_q & ~bclk_s3_q;
  assign boundary = lr_s2_q != lr_prev_q;
  assign pad      = CW'(SAMPLE_WIDTH) - cnt_q;

  // All three pins share one synchronizer depth so they stay mutually aligned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      lr_s1_q   <= 1'b0;
      lr_s2_q   <= 1'b0;
      sd_s1_q   <= 1'b0;
      sd_s2_q   <= 1'b0;
    end else begin
      bclk_s1_q <= bus.i2s_bclk;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      lr_s1_q   <= bus.i2s_lrclk;
      lr_s2_q   <= lr_s1_q;
      sd_s1_q   <= bus.i2s_sdata;
      sd_s2_q   <= sd_s1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    lr_prev_d  = lr_prev_q;
    primed_d   = primed_q;
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    cmt_d      = 1'b0;
    cmt_chan_d = chan_q;
    cmt_err_d  = 1'b0;
    cmt_word_d = cmt_word_q;
    if (rise) begin
      lr_prev_d = lr_s2_q;
      primed_d  = 1'b1;
      unique case (state_q)
        SYNC: begin
          if (primed_q && boundary && !lr_s2_q) begin
            state_d = SHIFT;
            chan_d  = 1'b0;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end
        SHIFT: begin
          if (boundary) begin
            // Short slot: flush the partial word left-aligned, then restart on the new channel.
            cmt_d      = 1'b1;
            cmt_err_d  = 1'b1;
            cmt_word_d = shreg_q << pad;
            chan_d     = lr_s2_q;
            cnt_d      = '0;
            shreg_d    = '0;
          end else begin
            shreg_d = {shreg_q[SAMPLE_WIDTH-2:0], sd_s2_q};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(SAMPLE_WIDTH - 1)) begin
              cmt_d      = 1'b1;
              cmt_word_d = {shreg_q[SAMPLE_WIDTH-2:0], sd_s2_q};
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (boundary) begin
            state_d = SHIFT;
            chan_d  = lr_s2_q;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= SYNC;
      lr_prev_q  <= 1'b0;
      primed_q   <= 1'b0;
      chan_q     <= 1'b0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      cmt_q      <= 1'b0;
      cmt_chan_q <= 1'b0;
      cmt_err_q  <= 1'b0;
      cmt_word_q <= '0;
    end else begin
      state_q    <= state_d;
      lr_prev_q  <= lr_prev_d;
      primed_q   <= primed_d;
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      cmt_q      <= cmt_d;
      cmt_chan_q <= cmt_chan_d;
      cmt_err_q  <= cmt_err_d;
      cmt_word_q <= cmt_word_d;
    end
  end

  // A right word is only published when a left word from the same frame is waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      left_hold_q   <= '0;
      left_valid_q  <= 1'b0;
      line_l_q      <= '0;
      line_r_q      <= '0;
      new_sample_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      new_sample_q  <= 1'b0;
      frame_error_q <= cmt_q & cmt_err_q;
      if (cmt_q) begin
        if (!cmt_chan_q) begin
          left_hold_q  <= cmt_word_q;
          left_valid_q <= 1'b1;
        end else if (left_valid_q) begin
          line_l_q     <= left_hold_q;
          line_r_q     <= cmt_word_q;
          new_sample_q <= 1'b1;
          left_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.line_in_l   = line_l_q;
  assign bus.line_in_r   = line_r_q;
  assign bus.new_sample  = new_sample_q;
  assign bus.frame_error = frame_error_q;
  assign bus.locked      = (state_q != SYNC);
endmodule

// File: tb/tb_i2s_line_in_receiver.sv
// Self-checking bench: drives I2S slots bit by bit and compares every strobe
// against a slot-level reference model of the receiver's observable behaviour.
module tb_i2s_line_in_receiver;
  localparam int unsigned SW = 24;

  typedef struct {
    logic          ns;
    logic          fe;
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  i2s_line_in_if #(.SAMPLE_WIDTH(SW)) bus ();

  i2s_line_in_receiver #(.SAMPLE_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state, advanced once per slot.
  ev_t           exp_q[$];
  logic          m_seen, m_prev_lr, m_locked, m_have_left;
  logic [SW-1:0] m_left;
  logic          m_pend, m_pend_ch;
  logic [SW-1:0] m_pend_w;

  int unsigned H = 16;
  int unsigned t_rrise = 0;
  logic        spacing_on = 1'b0;
  logic        have_prev  = 1'b0;
  int unsigned prev_cyc   = 0;

  task automatic model_reset();
    m_seen      = 1'b0;
    m_prev_lr   = 1'b0;
    m_locked    = 1'b0;
    m_have_left = 1'b0;
    m_left      = '0;
    m_pend      = 1'b0;
    m_pend_ch   = 1'b0;
    m_pend_w    = '0;
  endtask

  task automatic commit(input logic ch, input logic [SW-1:0] w, input logic err);
    ev_t e;
    if (!ch) begin
      m_left      = w;
      m_have_left = 1'b1;
      if (err) begin e = '{1'b0, 1'b1, '0, '0}; exp_q.push_back(e); end
    end else if (m_have_left) begin
      e = '{1'b1, err, m_left, w};
      exp_q.push_back(e);
      m_have_left = 1'b0;
    end else if (err) begin
      e = '{1'b0, 1'b1, '0, '0};
      exp_q.push_back(e);
    end
  endtask

  // One lrclk phase of n bclk periods; position 0 is the delay bit.
  // fill: 0/1 constant trailing bits, 2 random. start>0 sends only a tail fragment.
  task automatic send_slot(input logic lr, input int n, input logic [SW-1:0] word,
                           input int dlen, input int fill, input int start, input int rst_at);
    logic          st [64];
    logic [SW-1:0] cap;
    int            k;
    for (int p = 0; p < n; p++) begin
      if (p == 0)          st[p] = 1'($urandom);
      else if (p <= dlen)  st[p] = word[dlen-p];
      else if (fill == 2)  st[p] = 1'($urandom);
      else                 st[p] = fill[0];
    end
    if (start == 0) begin
      if (m_pend) begin commit(m_pend_ch, m_pend_w, 1'b1); m_pend = 1'b0; end
      if (!m_locked && m_seen && m_prev_lr && !lr) m_locked = 1'b1;
      if (m_locked && rst_at < 0) begin
        k   = (n - 1 < int'(SW)) ? n - 1 : int'(SW);
        cap = '0;
        for (int p = 1; p <= k; p++) cap = {cap[SW-2:0], st[p]};
        cap = cap << (int'(SW) - k);
        if (k == int'(SW)) commit(lr, cap, 1'b0);
        else begin m_pend = 1'b1; m_pend_ch = lr; m_pend_w = cap; end
      end
    end
    for (int p = start; p < n; p++) begin
      bus.i2s_bclk  = 1'b0;
      bus.i2s_lrclk = lr;
      bus.i2s_sdata = st[p];
      for (int unsigned c = 0; c < H; c++) begin
        @(negedge clk);
        if (p == rst_at && c == 0) reset = 1'b0;
        if (p == rst_at && c == 1) begin
          reset = 1'b1;
          check("rst_mid_line_in_l",   bus.line_in_l,   '0);
          check("rst_mid_line_in_r",   bus.line_in_r,   '0);
          check("rst_mid_new_sample",  bus.new_sample,  '0);
          check("rst_mid_frame_error", bus.frame_error, '0);
          check("rst_mid_locked",      bus.locked,      '0);
          model_reset();
        end
      end
      bus.i2s_bclk = 1'b1;
      if (lr && p == int'(SW)) t_rrise = cyc;
      for (int unsigned c = 0; c < H; c++) @(negedge clk);
      if (p == 0) check("locked", bus.locked, m_locked);
    end
    m_seen    = 1'b1;
    m_prev_lr = lr;
  endtask

  task automatic send_frame(input int n, input logic [SW-1:0] l, input logic [SW-1:0] r,
                            input int fill);
    send_slot(1'b0, n, l, SW, fill, 0, -1);
    send_slot(1'b1, n, r, SW, fill, 0, -1);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (reset && (bus.new_sample || bus.frame_error)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {bus.new_sample, bus.frame_error}, '0);
      end else begin
        e = exp_q.pop_front();
        check("new_sample",  bus.new_sample,  e.ns);
        check("frame_error", bus.frame_error, e.fe);
        if (e.ns) begin
          check("line_in_l", bus.line_in_l, e.l);
          check("line_in_r", bus.line_in_r, e.r);
          if (!e.fe) begin
            check("latency", 64'(cyc - t_rrise), 64'd4);
            if (spacing_on && have_prev) check("spacing", 64'(cyc - prev_cyc), 64'(128 * H));
            prev_cyc  = cyc;
            have_prev = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    reset         = 1'b0;
    bus.i2s_bclk  = 1'b0;
    bus.i2s_lrclk = 1'b1;
    bus.i2s_sdata = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_line_in_l",   bus.line_in_l,   '0);
    check("rst_line_in_r",   bus.line_in_r,   '0);
    check("rst_new_sample",  bus.new_sample,  '0);
    check("rst_frame_error", bus.frame_error, '0);
    check("rst_locked",      bus.locked,      '0);
    reset = 1'b1;

    // Startup in the middle of a right slot.
    send_slot(1'b1, 32, '0, 0, 2, 10, -1);
    check("locked_startup", bus.locked, '0);

    // Nominal frame, bclk period 32 clk.
    send_frame(32, 24'h123456, 24'hABCDEF, 0);
    repeat (8) @(negedge clk);
    check("nominal_l", bus.line_in_l, 24'h123456);
    check("nominal_r", bus.line_in_r, 24'hABCDEF);

    // Overlong slots with eight trailing ones.
    send_frame(33, 24'h123456, 24'hABCDEF, 1);
    repeat (8) @(negedge clk);
    check("overlong_l", bus.line_in_l, 24'h123456);
    check("overlong_r", bus.line_in_r, 24'hABCDEF);

    // Short slots carrying 16 bits each.
    send_slot(1'b0, 17, 24'h00BEEF, 16, 0, 0, -1);
    send_slot(1'b1, 17, 24'h001234, 16, 0, 0, -1);

    // Full scale, back to back.
    H          = 4;
    spacing_on = 1'b1;
    have_prev  = 1'b0;
    for (int f = 0; f < 4; f++) send_frame(32, 24'h800000, 24'h7FFFFF, 0);
    repeat (8) @(negedge clk);
    spacing_on = 1'b0;
    check("fullscale_l", bus.line_in_l, 24'h800000);
    check("fullscale_r", bus.line_in_r, 24'h7FFFFF);

    // Random words and slot lengths, including short slots.
    for (int f = 0; f < 6; f++) begin
      send_slot(1'b0, int'($urandom_range(34, 20)), SW'($urandom), SW, 2, 0, -1);
      send_slot(1'b1, int'($urandom_range(34, 20)), SW'($urandom), SW, 2, 0, -1);
    end

    // Reset pulse during left-slot bit 10, then recovery.
    send_slot(1'b0, 32, SW'($urandom), SW, 2, 0, 10);
    send_slot(1'b1, 32, SW'($urandom), SW, 2, 0, -1);
    send_frame(32, SW'($urandom), SW'($urandom), 2);
    send_slot(1'b0, 32, SW'($urandom), SW, 2, 0, -1);

    repeat (40) @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
